// File: rtl/serial_pkg.sv
// Encodings shared by the serial frame transmitter and the matching receiver.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } frame_state_e;

   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Free-running bit-period counter; last marks the final clock of each serial bit.
module bit_tick_counter #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic last
);

   localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] TERMINAL = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] count_q, count_d;

   // With one clock per bit the count is stuck at 0 and last is always high.
   assign last = (count_q == TERMINAL);

   always_comb begin
      count_d = count_q;
      if (clear || last) begin
         count_d = '0;
      end else begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Handshaked parallel-to-serial transmitter: start bit, N data bits, stop bit.
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int unsigned N            = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          MSB_FIRST    = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   localparam int unsigned   BW       = $clog2(N);
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

   frame_state_e  state_q, state_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          tick_last;
   logic          tick_clear;
   logic          accept;

   bit_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .clear(tick_clear),
      .last (tick_last)
   );

   assign accept     = in_valid && in_ready;
   assign tick_clear = (state_q == IDLE) || accept;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         IDLE: ;
         START: begin
            if (tick_last) state_d = DATA;
         end
         DATA: begin
            if (tick_last) begin
               shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         STOP: begin
            if (tick_last) state_d = IDLE;
         end
      endcase
      // Acceptance only happens in IDLE or the final STOP cycle; it overrides both.
      if (accept) begin
         state_d   = START;
         shift_d   = in_data;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      tx = LINE_IDLE;
      unique case (state_q)
         IDLE:  tx = LINE_IDLE;
         START: tx = 1'b0;
         DATA:  tx = MSB_FIRST ? shift_q[N-1] : shift_q[0];
         STOP:  tx = 1'b1;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == STOP) && tick_last;
   assign in_ready = (state_q == IDLE) || done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboarded bench for serial_frame_tx in LSB/4-clk, MSB/4-clk and LSB/1-clk builds.
module tb_serial_frame_tx;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       a_valid, a_ready, a_tx, a_busy, a_done;
   logic [7:0] a_data;
   logic       m_valid, m_ready, m_tx, m_busy, m_done;
   logic [7:0] m_data;
   logic       f_valid, f_ready, f_tx, f_busy, f_done;
   logic [7:0] f_data;

   serial_frame_tx #(.N(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
      .tx(a_tx), .busy(a_busy), .done(a_done)
   );
   serial_frame_tx #(.N(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .in_valid(m_valid), .in_ready(m_ready), .in_data(m_data),
      .tx(m_tx), .busy(m_busy), .done(m_done)
   );
   serial_frame_tx #(.N(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) dut_f (
      .clk(clk), .reset(reset), .in_valid(f_valid), .in_ready(f_ready), .in_data(f_data),
      .tx(f_tx), .busy(f_busy), .done(f_done)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 0;

   // Per-cycle expectation, packed as {tx, busy, done, in_ready}.
   logic [3:0] exp_q[$];
   logic [3:0] obs;

   always_comb begin
      case (sel)
         1:       obs = {m_tx, m_busy, m_done, m_ready};
         2:       obs = {f_tx, f_busy, f_done, f_ready};
         default: obs = {a_tx, a_busy, a_done, a_ready};
      endcase
   end

   task automatic push_frame(input logic [7:0] d, input bit msb, input int cpb);
      logic [9:0] bits;
      bit         fin;
      bits[0] = 1'b0;
      bits[9] = 1'b1;
      for (int b = 0; b < 8; b++) bits[b+1] = msb ? d[7-b] : d[b];
      for (int b = 0; b < 10; b++) begin
         for (int t = 0; t < cpb; t++) begin
            fin = (b == 9) && (t == cpb - 1);
            exp_q.push_back({bits[b], 1'b1, fin, fin});
         end
      end
   endtask

   task automatic push_idle(input int n);
      repeat (n) exp_q.push_back(4'b1001);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({a_tx, a_busy, a_done, a_ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL reset_a: got tx,busy,done,ready=%b required 1001",
                  {a_tx, a_busy, a_done, a_ready});
      end
      n_checks++;
      if ({m_tx, m_busy, m_done, m_ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL reset_m: got tx,busy,done,ready=%b required 1001",
                  {m_tx, m_busy, m_done, m_ready});
      end
      n_checks++;
      if ({f_tx, f_busy, f_done, f_ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL reset_f: got tx,busy,done,ready=%b required 1001",
                  {f_tx, f_busy, f_done, f_ready});
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lsb_frame();
      logic [3:0] e;
      int         cyc = 0;
      sel = 0;
      a_data  = 8'hA5;
      a_valid = 1'b1;
      push_frame(8'hA5, 1'b0, 4);
      push_idle(2);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            a_valid = 1'b0;
            a_data  = 8'h00;
         end
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL lsb_a5 cyc %0d: got tx,busy,done,ready=%b required %b", cyc, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] e;
      int         cyc = 0;
      int         busy_n = 0;
      int         done_n = 0;
      sel = 0;
      a_data  = 8'h3C;
      a_valid = 1'b1;
      push_frame(8'h3C, 1'b0, 4);
      push_frame(8'hC3, 1'b0, 4);
      push_idle(2);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b cyc %0d: got tx,busy,done,ready=%b required %b", cyc, obs, e);
         end
         busy_n += int'(a_busy);
         done_n += int'(a_done);
         if (cyc == 40) a_data = 8'hC3;
         if (cyc == 41) a_valid = 1'b0;
      end
      n_checks++;
      if (busy_n != 80) begin
         n_fail++;
         $display("FAIL b2b_busy_cycles: got %0d required 80", busy_n);
      end
      n_checks++;
      if (done_n != 2) begin
         n_fail++;
         $display("FAIL b2b_done_pulses: got %0d required 2", done_n);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [3:0] e;
      int         cyc = 0;
      int         done_n = 0;
      sel = 0;
      a_data  = 8'h55;
      a_valid = 1'b1;
      push_frame(8'h55, 1'b0, 4);
      while (exp_q.size() > 15) void'(exp_q.pop_back());
      push_idle(3);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rst_mid cyc %0d: got tx,busy,done,ready=%b required %b", cyc, obs, e);
         end
         done_n += int'(a_done);
         if (cyc == 1)  a_valid = 1'b0;
         if (cyc == 15) reset = 1'b0;
         if (cyc == 16) reset = 1'b1;
      end
      n_checks++;
      if (done_n != 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_done: got %0d done pulses required 0", done_n);
      end
      cyc = 0;
      a_data  = 8'h0F;
      a_valid = 1'b1;
      push_frame(8'h0F, 1'b0, 4);
      push_idle(1);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) a_valid = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL post_rst_0f cyc %0d: got tx,busy,done,ready=%b required %b",
                     cyc, obs, e);
         end
      end
   endtask

   task automatic test_msb_first();
      logic [3:0] e;
      int         cyc = 0;
      sel = 1;
      m_data  = 8'h80;
      m_valid = 1'b1;
      push_frame(8'h80, 1'b1, 4);
      push_idle(2);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) m_valid = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL msb_80 cyc %0d: got tx,busy,done,ready=%b required %b", cyc, obs, e);
         end
      end
   endtask

   task automatic test_one_clk_per_bit();
      logic [3:0] e;
      int         cyc = 0;
      sel = 2;
      f_data  = 8'hFF;
      f_valid = 1'b1;
      push_frame(8'hFF, 1'b0, 1);
      push_idle(2);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) f_valid = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL cpb1_ff cyc %0d: got tx,busy,done,ready=%b required %b", cyc, obs, e);
         end
      end
   endtask

   task automatic test_ignore_while_busy();
      logic [3:0] e;
      int         cyc = 0;
      sel = 0;
      a_data  = 8'h96;
      a_valid = 1'b1;
      push_frame(8'h96, 1'b0, 4);
      push_idle(8);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         cyc++;
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ignore_busy cyc %0d: got tx,busy,done,ready=%b required %b",
                     cyc, obs, e);
         end
         if (cyc == 1) a_valid = 1'b0;
         if (cyc == 20) begin
            a_valid = 1'b1;
            a_data  = 8'h00;
         end
         if (cyc == 21) a_valid = 1'b0;
      end
   endtask

   initial begin
      reset   = 1'b0;
      a_valid = 1'b0;
      a_data  = 8'h00;
      m_valid = 1'b0;
      m_data  = 8'h00;
      f_valid = 1'b0;
      f_data  = 8'h00;
      test_reset();
      test_lsb_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_msb_first();
      test_one_clk_per_bit();
      test_ignore_while_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
